// File: rtl/led_ctrl_pkg.sv
// Shared definitions for the LED sequencer: opcodes, FSM encoding, widths,
// the command payload and the step-period helper.
package led_ctrl_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned ARG_W = 8;
  localparam int unsigned LED_W = 8;
  localparam int unsigned SPD_W = 2;
  localparam int unsigned PRE_W = 32;

  typedef enum logic [OP_W-1:0] {
    OP_NOP       = 3'd0,
    OP_START     = 3'd1,
    OP_STOP      = 3'd2,
    OP_SET_DIR   = 3'd3,
    OP_LOAD      = 3'd4,
    OP_SET_SPEED = 3'd5,
    OP_CLEAR     = 3'd6,
    OP_RSVD      = 3'd7
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } seq_state_e;

  typedef struct packed {
    cmd_op_e          op;
    logic [ARG_W-1:0] arg;
  } cmd_t;

  // Step period: base frequency halved per speed level, never below one cycle.
  function automatic logic [PRE_W-1:0] step_period(input logic [PRE_W-1:0] freq,
                                                   input logic [SPD_W-1:0] spd);
    logic [PRE_W-1:0] p;
    p = freq >> spd;
    return (p == '0) ? PRE_W'(1) : p;
  endfunction

endpackage

// File: rtl/led_seq_ctrl_tick_prescaler.sv
// tick_prescaler: free-running step-period counter.
// Ports:
//   clk, rst_n  clock, synchronous active-low reset
//   enable      advance the count this cycle (wraps to 0 at period-1)
//   clear       force the count to 0 (wins over enable)
//   period      current step period in cycles (>= 1)
//   tc_c        combinational terminal-count strobe (count == period-1)
module tick_prescaler
  import led_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clear,
  input  logic [PRE_W-1:0] period,
  output logic             tc_c
);

  logic [PRE_W-1:0] cnt_q;

  assign tc_c = (cnt_q == (period - PRE_W'(1)));

  // Count register; holding enable low freezes the value for resume.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= tc_c ? '0 : (cnt_q + PRE_W'(1));
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: command-driven 8-bit LED counter sequencer.
// Optional build macro: LED_SEQ_BOUNCE_EN -- bounce at 0x00/0xFF instead of
// wrapping modulo 256.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   cmd_valid/cmd_ready command handshake (ready drops only on a step cycle)
//   cmd_op, cmd_arg     opcode and argument
//   leds                current counter value (registered)
//   running             high while in RUN (registered)
//   dir                 0 = up, 1 = down (registered)
//   tick                pulse in the first cycle of a new stepped leds value
//   wrap                pulse with tick when the step crossed an end
module led_seq_ctrl
  import led_ctrl_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [OP_W-1:0]  cmd_op,
  input  logic [ARG_W-1:0] cmd_arg,
  output logic [LED_W-1:0] leds,
  output logic             running,
  output logic             dir,
  output logic             tick,
  output logic             wrap
);

  seq_state_e       state_q, state_d;
  logic [LED_W-1:0] leds_q, leds_d;
  logic             dir_q, dir_d;
  logic [SPD_W-1:0] spd_q, spd_d;
  logic             tick_q, tick_d;
  logic             wrap_q, wrap_d;
  logic             running_q;

  logic             pre_en, pre_clr, pre_tc_c;
  logic [PRE_W-1:0] period_c;
  logic             step_c, accept_c, at_end_c;
  cmd_t             cmd_c;

  assign cmd_c    = '{op: cmd_op_e'(cmd_op), arg: cmd_arg};
  assign period_c = step_period(PRE_W'(CLK_FREQ), spd_q);

  // A step and a command never share a cycle: refuse commands on step cycles.
  assign step_c    = (state_q == ST_RUN) && pre_tc_c;
  assign cmd_ready = !step_c;
  assign accept_c  = cmd_valid && cmd_ready;
  assign at_end_c  = dir_q ? (leds_q == '0) : (leds_q == '1);

  tick_prescaler u_prescaler (
    .clk    (clk),
    .rst_n  (rst_n),
    .enable (pre_en),
    .clear  (pre_clr),
    .period (period_c),
    .tc_c   (pre_tc_c)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state, datapath and prescaler control
  always_comb begin
    state_d = state_q;
    leds_d  = leds_q;
    dir_d   = dir_q;
    spd_d   = spd_q;
    tick_d  = 1'b0;
    wrap_d  = 1'b0;
    pre_en  = (state_q == ST_RUN);
    pre_clr = 1'b0;

    if (accept_c) begin
      unique case (cmd_c.op)
        OP_START: begin
          // Entering RUN does not count the entry cycle; HOLD resumes its value.
          if (state_q != ST_RUN) begin
            state_d = ST_RUN;
            pre_en  = 1'b0;
          end
        end
        OP_STOP: begin
          if (state_q == ST_RUN) begin
            state_d = ST_HOLD;
            pre_en  = 1'b0;
          end
        end
        OP_SET_DIR: dir_d = cmd_c.arg[0];
        OP_LOAD: begin
          leds_d  = cmd_c.arg;
          pre_clr = 1'b1;
        end
        OP_SET_SPEED: begin
          spd_d   = cmd_c.arg[SPD_W-1:0];
          pre_clr = 1'b1;
        end
        OP_CLEAR: begin
          state_d = ST_IDLE;
          leds_d  = '0;
          pre_clr = 1'b1;
        end
        default: ;
      endcase
    end else if (step_c) begin
      tick_d = 1'b1;
      wrap_d = at_end_c;
`ifdef LED_SEQ_BOUNCE_EN
      if (at_end_c) begin
        dir_d  = ~dir_q;
        leds_d = dir_q ? (leds_q + LED_W'(1)) : (leds_q - LED_W'(1));
      end else begin
        leds_d = dir_q ? (leds_q - LED_W'(1)) : (leds_q + LED_W'(1));
      end
`else
      leds_d = dir_q ? (leds_q - LED_W'(1)) : (leds_q + LED_W'(1));
`endif
    end
  end

  // Output and configuration registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      leds_q    <= '0;
      dir_q     <= 1'b0;
      spd_q     <= '0;
      tick_q    <= 1'b0;
      wrap_q    <= 1'b0;
      running_q <= 1'b0;
    end else begin
      leds_q    <= leds_d;
      dir_q     <= dir_d;
      spd_q     <= spd_d;
      tick_q    <= tick_d;
      wrap_q    <= wrap_d;
      running_q <= (state_d == ST_RUN);
    end
  end

  assign leds    = leds_q;
  assign dir     = dir_q;
  assign tick    = tick_q;
  assign wrap    = wrap_q;
  assign running = running_q;

endmodule
